wb_burst_master: RTL and testbench
==================================

Name: wb_burst_master

Overview:
- Synthesizable Wishbone initiator (bus master) that drives the system-side Wishbone slave port of the SDRAM controller (sdrc_top).
- Accepts one command at a time: address, beat count, direction and seed. For each command it issues one incrementing-burst cycle.
- Write data is a deterministic pattern. Read data is checked against the same pattern, so the block works as on-chip traffic generator and self-checker (BIST) in front of the SDRAM path.

Parameters:
- dw, 32, Wishbone data width (32 only supported; pattern defined for 32).
- aw, 32, Wishbone address width.
- TIMEOUT, 1024, max sys_clk cycles with stb high and no ack before the cycle is aborted.

Ports:
- sys_clk  in  1  system clock, all logic rising-edge.
- RESETN  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_we  in  1  1 = write burst, 0 = read-and-check burst.
- cmd_addr  in  aw  start byte address, word aligned ([1:0] ignored, forced 0).
- cmd_len  in  8  beats minus one (0 = 1 beat, 255 = 256 beats).
- cmd_seed  in  dw  pattern seed.
- done  out  1  one-cycle pulse when a command finishes (normal or timeout).
- timeout_err  out  1  sticky; set on abort, cleared by err_clr.
- err_cnt  out  16  read mismatch count, saturates at 16'hFFFF.
- first_err_addr  out  aw  address of the first mismatch since the last clear.
- err_clr  in  1  synchronous clear of err_cnt, first_err_addr and timeout_err.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe and write enable.
- wb_addr_o  out  aw  beat address.
- wb_dat_o  out  dw  write data.
- wb_sel_o  out  dw/8  byte selects, always all ones while stb is high.
- wb_cti_o  out  3  cycle type identifier.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  dw  read data.

Behaviour:
- Reset (async, RESETN low): state IDLE. Outputs:
  - cmd_ready=1
  - all wb_* outputs 0
  - done=0, timeout_err=0, err_cnt=0, first_err_addr=0
  - Reset mid-burst drops cyc/stb immediately; no further beats are issued.
- All outputs are registered.
- Pattern for beat address A: P(A) = A ^ cmd_seed.
- State IDLE:
  - On accept, latch cmd fields.
  - Next cycle: cyc=stb=1, we=cmd_we, addr=cmd_addr, dat=P(cmd_addr), beats_left=cmd_len.
  - Go to BUS.
- State BUS:
  - cti encoding:
    - single beat (cmd_len=0): 3'b000
    - otherwise: 3'b010 on every beat except the last, 3'b111 on the last
  - On each cycle with stb & ack:
    - If read, compare wb_dat_i to P(wb_addr_o).
    - If beats_left != 0: addr += 4, dat = P(addr+4), beats_left -= 1, stb stays high (zero-wait bursts allowed: back-to-back acks each advance one beat).
    - If beats_left == 0 (last beat): cyc=stb=we=cti=0 next cycle, done=1 for that cycle, state IDLE.
  - cmd_ready=1 again in the cycle done is high; a new command may be accepted that same cycle.
- Address wrap: addr increments modulo 2^aw with no boundary check.
- Timeout:
  - Counter resets on each ack and counts while stb is high.
  - When it reaches TIMEOUT: drop cyc/stb next cycle, set timeout_err, pulse done, return to IDLE.
  - A late ack after the abort is ignored.
- Mismatch:
  - err_cnt += 1, saturating.
  - If err_cnt was 0 before this event, capture first_err_addr = wb_addr_o.
- err_clr in the same cycle as a mismatch: clear is applied first, then the mismatch counts, giving err_cnt=1 and a captured address.
- cmd_valid while busy: ignored, cmd_ready stays 0; no queueing.
- ack while stb is low: ignored.

Decomposition:
- Package wb_master_pkg:
  - state enum {IDLE, BUS}
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111
  - byte increment constant 4
  - pattern function P()
- One natural sub-module: wb_err_checker (compare, saturating counter, first-address capture, err_clr priority).
- Main FSM, address/beat counters and timeout counter stay in the top.

Test Plan:
- Write burst, addr=32'h0000_0040, len=7, seed=32'hA5A5_0000, slave always acks:
  - 8 beats, addresses 40..5C
  - dat = addr ^ seed
  - cti 010 x7 then 111
  - done one cycle after the 8th ack
- Read back the same region with the SDRAM model:
  - err_cnt=0, done pulse, no timeout_err.
- Read with wrong seed 32'hA5A5_0001, len=3:
  - err_cnt=4, first_err_addr=32'h40.
  - Then err_clr coincident with a new mismatch gives err_cnt=1.
- Single beat, len=0, addr=32'h100, write:
  - cti=000, exactly one stb/ack, done on the following cycle.
- Slave never acks, TIMEOUT=16:
  - cyc drops 16 cycles after stb rose
  - timeout_err=1, done pulse
  - a later ack is ignored.
- RESETN asserted mid-burst (after beat 3 of 8):
  - cyc/stb low immediately, all status 0
  - after release, cmd_ready=1 and a new command runs normally.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types, constants and the test-pattern function for the Wishbone
// burst master and its read-data checker.
package wb_master_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Byte-address step between consecutive 32-bit beats
    localparam int unsigned BYTE_INC = 4;

    // Width the pattern is defined for
    localparam int PAT_W = 32;

    // Data pattern carried by beat address A: P(A) = A ^ seed
    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                                 input logic [PAT_W-1:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/wb_err_checker.sv
// Read-data checker: compares each acknowledged read beat with the expected
// pattern, keeps a saturating mismatch count and the first failing address.
// A clear arriving together with a mismatch is applied before the mismatch.
module wb_err_checker
    import wb_master_pkg::*;
#(
    parameter int dw = 32,
    parameter int aw = 32
) (
    input  logic          sys_clk,
    input  logic          RESETN,
    input  logic          err_clr,
    input  logic          chk_en,
    input  logic [dw-1:0] rd_data,
    input  logic [aw-1:0] beat_addr,
    input  logic [dw-1:0] seed,
    output logic [15:0]   err_cnt,
    output logic [aw-1:0] first_err_addr
);

    logic [15:0]   cnt_reg,   cnt_next;
    logic [aw-1:0] first_reg, first_next;
    logic [dw-1:0] exp_data;
    logic          mismatch;

    assign exp_data = dw'(pattern(PAT_W'(beat_addr), PAT_W'(seed)));
    assign mismatch = chk_en && (rd_data != exp_data);

    // Clear first, then fold in this cycle's mismatch (capture before increment)
    always_comb begin
        cnt_next   = err_clr ? 16'h0000 : cnt_reg;
        first_next = err_clr ? '0 : first_reg;
        if (mismatch) begin
            if (cnt_next == 16'h0000) begin
                first_next = beat_addr;
            end
            if (cnt_next != 16'hFFFF) begin
                cnt_next = cnt_next + 16'd1;
            end
        end
    end

    // Error status registers
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            cnt_reg   <= 16'h0000;
            first_reg <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            first_reg <= first_next;
        end
    end

    assign err_cnt        = cnt_reg;
    assign first_err_addr = first_reg;

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst initiator used as traffic generator and
// self-checker in front of the SDRAM controller. One command at a time:
// writes the address-derived pattern, or reads it back and counts mismatches.
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [aw-1:0]   cmd_addr,
    input  logic [7:0]      cmd_len,
    input  logic [dw-1:0]   cmd_seed,
    output logic            done,
    output logic            timeout_err,
    output logic [15:0]     err_cnt,
    output logic [aw-1:0]   first_err_addr,
    input  logic            err_clr,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [aw-1:0]   wb_addr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [dw-1:0]   wb_dat_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_reg, state_next;
    logic          ready_reg, ready_next;
    logic          cyc_reg,   cyc_next;
    logic          stb_reg,   stb_next;
    logic          we_reg,    we_next;
    logic [aw-1:0] addr_reg,  addr_next;
    logic [dw-1:0] dat_reg,   dat_next;
    logic [2:0]    cti_reg,   cti_next;
    logic          done_reg,  done_next;
    logic          terr_reg,  terr_next;
    logic [7:0]    beats_reg, beats_next;
    logic [dw-1:0] seed_reg,  seed_next;
    logic [TW-1:0] tmo_reg,   tmo_next;
    logic          chk_en;

    logic [aw-1:0] start_addr;
    logic [aw-1:0] step_addr;

    // Low address bits are dropped so every beat is word aligned
    assign start_addr = cmd_addr & ~aw'(3);
    assign step_addr  = addr_reg + aw'(BYTE_INC);

    // Next-state and next-output logic for the IDLE/BUS controller
    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        stb_next   = stb_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        dat_next   = dat_reg;
        cti_next   = cti_reg;
        done_next  = 1'b0;
        terr_next  = err_clr ? 1'b0 : terr_reg;
        beats_next = beats_reg;
        seed_next  = seed_reg;
        tmo_next   = tmo_reg;
        chk_en     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && ready_reg) begin
                    state_next = BUS;
                    cyc_next   = 1'b1;
                    stb_next   = 1'b1;
                    we_next    = cmd_we;
                    addr_next  = start_addr;
                    dat_next   = dw'(pattern(PAT_W'(start_addr), PAT_W'(cmd_seed)));
                    cti_next   = (cmd_len == 8'd0) ? CTI_CLASSIC : CTI_INCR;
                    beats_next = cmd_len;
                    seed_next  = cmd_seed;
                    tmo_next   = '0;
                end
            end
            BUS: begin
                if (stb_reg && wb_ack_i) begin
                    chk_en   = !we_reg;
                    tmo_next = '0;
                    if (beats_reg != 8'd0) begin
                        addr_next  = step_addr;
                        dat_next   = dw'(pattern(PAT_W'(step_addr), PAT_W'(seed_reg)));
                        beats_next = beats_reg - 8'd1;
                        cti_next   = (beats_reg == 8'd1) ? CTI_END : CTI_INCR;
                    end else begin
                        state_next = IDLE;
                        cyc_next   = 1'b0;
                        stb_next   = 1'b0;
                        we_next    = 1'b0;
                        cti_next   = CTI_CLASSIC;
                        done_next  = 1'b1;
                    end
                end else if (stb_reg) begin
                    // stb has been high TIMEOUT cycles without an ack: abort
                    if (tmo_reg == TW'(TIMEOUT - 1)) begin
                        state_next = IDLE;
                        cyc_next   = 1'b0;
                        stb_next   = 1'b0;
                        we_next    = 1'b0;
                        cti_next   = CTI_CLASSIC;
                        done_next  = 1'b1;
                        terr_next  = 1'b1;
                    end else begin
                        tmo_next = tmo_reg + TW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == IDLE);
    end

    // State and registered outputs
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            dat_reg   <= '0;
            cti_reg   <= CTI_CLASSIC;
            done_reg  <= 1'b0;
            terr_reg  <= 1'b0;
            beats_reg <= 8'd0;
            seed_reg  <= '0;
            tmo_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= ready_next;
            cyc_reg   <= cyc_next;
            stb_reg   <= stb_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            dat_reg   <= dat_next;
            cti_reg   <= cti_next;
            done_reg  <= done_next;
            terr_reg  <= terr_next;
            beats_reg <= beats_next;
            seed_reg  <= seed_next;
            tmo_reg   <= tmo_next;
        end
    end

    // Every byte lane is enabled whenever a beat is offered
    genvar gi;
    generate
        for (gi = 0; gi < dw / 8; gi++) begin : g_sel
            assign wb_sel_o[gi] = stb_reg;
        end
    endgenerate

    wb_err_checker #(
        .dw(dw),
        .aw(aw)
    ) u_err_checker (
        .sys_clk        (sys_clk),
        .RESETN         (RESETN),
        .err_clr        (err_clr),
        .chk_en         (chk_en),
        .rd_data        (wb_dat_i),
        .beat_addr      (addr_reg),
        .seed           (seed_reg),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    assign cmd_ready   = ready_reg;
    assign done        = done_reg;
    assign timeout_err = terr_reg;
    assign wb_cyc_o    = cyc_reg;
    assign wb_stb_o    = stb_reg;
    assign wb_we_o     = we_reg;
    assign wb_addr_o   = addr_reg;
    assign wb_dat_o    = dat_reg;
    assign wb_cti_o    = cti_reg;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed testbench for wb_burst_master with a small zero-wait memory slave.
module tb_wb_burst_master;

    logic        sys_clk   = 1'b0;
    logic        RESETN    = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_we    = 1'b0;
    logic [31:0] cmd_addr  = 32'h0;
    logic [7:0]  cmd_len   = 8'h0;
    logic [31:0] cmd_seed  = 32'h0;
    logic        err_clr   = 1'b0;
    logic        cmd_ready, done, timeout_err;
    logic [15:0] err_cnt;
    logic [31:0] first_err_addr;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_addr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    logic        ack_en    = 1'b1;
    logic        force_ack = 1'b0;
    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;
    int cycle_n = 0;
    int done_cnt = 0;
    int stb_cnt = 0;
    int last_done_cyc = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_dat[$];
    logic [2:0]  log_cti[$];
    logic        log_we[$];
    int          log_cyc[$];

    always #5 sys_clk = ~sys_clk;

    wb_burst_master #(
        .dw(32),
        .aw(32),
        .TIMEOUT(16)
    ) dut (
        .sys_clk        (sys_clk),
        .RESETN         (RESETN),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_we         (cmd_we),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_seed       (cmd_seed),
        .done           (done),
        .timeout_err    (timeout_err),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .err_clr        (err_clr),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_addr_o      (wb_addr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_sel_o       (wb_sel_o),
        .wb_cti_o       (wb_cti_o),
        .wb_ack_i       (wb_ack_i),
        .wb_dat_i       (wb_dat_i)
    );

    // Zero-wait slave: combinational ack and read data
    assign wb_ack_i = (ack_en & wb_cyc_o & wb_stb_o) | force_ack;
    assign wb_dat_i = mem[wb_addr_o[11:2]];

    always @(posedge sys_clk) cycle_n <= cycle_n + 1;

    // Bus monitor, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (wb_stb_o) stb_cnt <= stb_cnt + 1;
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cycle_n;
        end
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            log_addr.push_back(wb_addr_o);
            log_dat.push_back(wb_dat_o);
            log_cti.push_back(wb_cti_o);
            log_we.push_back(wb_we_o);
            log_cyc.push_back(cycle_n);
            if (wb_we_o) mem[wb_addr_o[11:2]] <= wb_dat_o;
        end
    end

    task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [7:0] len,
                             input logic [31:0] seed, input logic clr);
        @(negedge sys_clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_seed  = seed;
        $display("cmd: we=%0d addr=%h len=%0d seed=%h clr=%0d", we, addr, len, seed, clr);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        err_clr   = clr;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        err_clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("FAIL reset_cyc_stb_we: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        checks++; if ({wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== 71'h0) begin errors++; $display("FAIL reset_wb_bus: got %h/%h/%h/%h expected all 0", wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o); end
        checks++; if ({done, timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_done_terr: got %b expected 00", {done, timeout_err}); end
        checks++; if (err_cnt !== 16'h0 || first_err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_status: got %h/%h expected 0/0", err_cnt, first_err_addr); end
    endtask

    task automatic test_write_burst();
        int base, d0;
        bit ok;
        logic [31:0] ea;
        base = log_addr.size();
        d0   = done_cnt;
        issue_cmd(1'b1, 32'h0000_0040, 8'd7, 32'hA5A5_0000, 1'b0);
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_done: got no done, required done within 50 cycles"); end
        checks++; if (log_addr.size() - base !== 8) begin errors++; $display("FAIL wr_beats: got %0d expected 8", log_addr.size() - base); end
        for (int i = 0; i < 8 && base + i < log_addr.size(); i++) begin
            ea = 32'h40 + 32'(4 * i);
            checks++; if (log_addr[base+i] !== ea) begin errors++; $display("FAIL wr_addr[%0d]: got %h expected %h", i, log_addr[base+i], ea); end
            checks++; if (log_dat[base+i] !== (ea ^ 32'hA5A5_0000)) begin errors++; $display("FAIL wr_dat[%0d]: got %h expected %h", i, log_dat[base+i], ea ^ 32'hA5A5_0000); end
            checks++; if (log_cti[base+i] !== ((i == 7) ? 3'b111 : 3'b010)) begin errors++; $display("FAIL wr_cti[%0d]: got %b expected %b", i, log_cti[base+i], (i == 7) ? 3'b111 : 3'b010); end
            checks++; if (log_we[base+i] !== 1'b1) begin errors++; $display("FAIL wr_we[%0d]: got %b expected 1", i, log_we[base+i]); end
        end
        checks++; if (log_cyc.size() > base && last_done_cyc !== log_cyc[log_cyc.size()-1] + 1) begin errors++; $display("FAIL wr_done_timing: got cycle %0d expected %0d", last_done_cyc, log_cyc[log_cyc.size()-1] + 1); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wr_done_pulses: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_read_back();
        int base, d0, nwe;
        bit ok;
        base = log_addr.size();
        d0   = done_cnt;
        issue_cmd(1'b0, 32'h0000_0040, 8'd7, 32'hA5A5_0000, 1'b0);
        wait_done(50, ok);
        nwe = 0;
        for (int i = base; i < log_we.size(); i++) if (log_we[i] !== 1'b0) nwe++;
        checks++; if (!ok) begin errors++; $display("FAIL rd_done: got no done, required done within 50 cycles"); end
        checks++; if (log_addr.size() - base !== 8) begin errors++; $display("FAIL rd_beats: got %0d expected 8", log_addr.size() - base); end
        checks++; if (nwe !== 0) begin errors++; $display("FAIL rd_we: got %0d write beats expected 0", nwe); end
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rd_err_cnt: got %0d expected 0", err_cnt); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rd_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rd_done_pulses: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_mismatch();
        bit ok;
        issue_cmd(1'b0, 32'h0000_0040, 8'd3, 32'hA5A5_0001, 1'b0);
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mm_done: got no done, required done within 50 cycles"); end
        checks++; if (err_cnt !== 16'd4) begin errors++; $display("FAIL mm_err_cnt: got %0d expected 4", err_cnt); end
        checks++; if (first_err_addr !== 32'h40) begin errors++; $display("FAIL mm_first_addr: got %h expected 00000040", first_err_addr); end
        // clear lands in the same cycle as one more mismatching beat
        issue_cmd(1'b0, 32'h0000_0044, 8'd0, 32'hA5A5_0001, 1'b1);
        wait_done(50, ok);
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL mm_clr_cnt: got %0d expected 1", err_cnt); end
        checks++; if (first_err_addr !== 32'h44) begin errors++; $display("FAIL mm_clr_addr: got %h expected 00000044", first_err_addr); end
    endtask

    task automatic test_single();
        int base, d0;
        bit ok;
        base = log_addr.size();
        d0   = done_cnt;
        issue_cmd(1'b1, 32'h0000_0100, 8'd0, 32'h1234_5678, 1'b0);
        wait_done(20, ok);
        checks++; if (!ok || log_addr.size() - base !== 1) begin errors++; $display("FAIL single_beats: got %0d beats done=%0d expected 1 beat and done", log_addr.size() - base, ok); end
        if (log_addr.size() > base) begin
            checks++; if (log_addr[base] !== 32'h100) begin errors++; $display("FAIL single_addr: got %h expected 00000100", log_addr[base]); end
            checks++; if (log_dat[base] !== 32'h1234_5778) begin errors++; $display("FAIL single_dat: got %h expected 12345778", log_dat[base]); end
            checks++; if (log_cti[base] !== 3'b000) begin errors++; $display("FAIL single_cti: got %b expected 000", log_cti[base]); end
            checks++; if (last_done_cyc !== log_cyc[base] + 1) begin errors++; $display("FAIL single_done_timing: got cycle %0d expected %0d", last_done_cyc, log_cyc[base] + 1); end
        end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_timeout();
        int base, d0, s0;
        bit ok;
        base   = log_addr.size();
        d0     = done_cnt;
        s0     = stb_cnt;
        ack_en = 1'b0;
        issue_cmd(1'b0, 32'h0000_0200, 8'd3, 32'h0, 1'b0);
        wait_done(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_done: got no done, required done within 60 cycles"); end
        checks++; if (stb_cnt - s0 !== 16) begin errors++; $display("FAIL to_stb_cycles: got %0d expected 16", stb_cnt - s0); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", timeout_err); end
        checks++; if (log_addr.size() - base !== 0) begin errors++; $display("FAIL to_beats: got %0d expected 0", log_addr.size() - base); end
        // late ack after the abort
        @(negedge sys_clk); force_ack = 1'b1;
        @(negedge sys_clk); force_ack = 1'b0;
        @(negedge sys_clk); #1;
        checks++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin errors++; $display("FAIL to_late_ack_bus: got %b expected 00", {wb_cyc_o, wb_stb_o}); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL to_late_ack_done: got %0d pulses expected 1", done_cnt - d0); end
        checks++; if (cmd_ready !== 1'b1 || err_cnt !== 16'd1) begin errors++; $display("FAIL to_late_ack_state: got ready=%b err_cnt=%0d expected 1/1", cmd_ready, err_cnt); end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        int base;
        base = log_addr.size();
        issue_cmd(1'b1, 32'h0000_0300, 8'd7, 32'h0F0F_F0F0, 1'b0);
        #1;
        for (int i = 0; i < 20; i++) begin
            if (log_addr.size() >= base + 3) break;
            @(negedge sys_clk); #1;
        end
        checks++; if (log_addr.size() - base !== 3) begin errors++; $display("FAIL rst_pre_beats: got %0d expected 3", log_addr.size() - base); end
        @(posedge sys_clk); #2;
        RESETN = 1'b0;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin errors++; $display("FAIL rst_mid_bus: got %b expected 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        checks++; if ({wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== 71'h0) begin errors++; $display("FAIL rst_mid_wb: got %h/%h/%h/%h expected all 0", wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o); end
        checks++; if ({done, timeout_err} !== 2'b00 || err_cnt !== 16'h0 || first_err_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_status: got done=%b terr=%b cnt=%0d first=%h expected 0", done, timeout_err, err_cnt, first_err_addr); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready); end
        @(negedge sys_clk); @(negedge sys_clk); #1;
        checks++; if (log_addr.size() - base !== 3) begin errors++; $display("FAIL rst_no_more_beats: got %0d expected 3", log_addr.size() - base); end
        @(negedge sys_clk);
        RESETN = 1'b1;
    endtask

    task automatic test_after_reset();
        int base;
        bit ok;
        base = log_addr.size();
        issue_cmd(1'b1, 32'h0000_0400, 8'd1, 32'h5555_AAAA, 1'b0);
        wait_done(20, ok);
        checks++; if (!ok || log_addr.size() - base !== 2) begin errors++; $display("FAIL post_rst_beats: got %0d beats done=%0d expected 2 and done", log_addr.size() - base, ok); end
        if (log_addr.size() - base >= 2) begin
            checks++; if (log_addr[base+1] !== 32'h404) begin errors++; $display("FAIL post_rst_addr: got %h expected 00000404", log_addr[base+1]); end
            checks++; if (log_dat[base+1] !== 32'h5555_AEAE) begin errors++; $display("FAIL post_rst_dat: got %h expected 5555aeae", log_dat[base+1]); end
            checks++; if ({log_cti[base], log_cti[base+1]} !== 6'b010_111) begin errors++; $display("FAIL post_rst_cti: got %b/%b expected 010/111", log_cti[base], log_cti[base+1]); end
        end
        issue_cmd(1'b0, 32'h0000_0400, 8'd1, 32'h5555_AAAA, 1'b0);
        wait_done(20, ok);
        checks++; if (!ok || err_cnt !== 16'd0) begin errors++; $display("FAIL post_rst_readback: got err_cnt=%0d done=%0d expected 0 and done", err_cnt, ok); end
    endtask

    task automatic test_wrap();
        int base;
        bit ok;
        base = log_addr.size();
        issue_cmd(1'b1, 32'hFFFF_FFFE, 8'd1, 32'h0000_0000, 1'b0);
        wait_done(20, ok);
        checks++; if (!ok || log_addr.size() - base !== 2) begin errors++; $display("FAIL wrap_beats: got %0d beats done=%0d expected 2 and done", log_addr.size() - base, ok); end
        if (log_addr.size() - base >= 2) begin
            checks++; if (log_addr[base] !== 32'hFFFF_FFFC || log_addr[base+1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h/%h expected fffffffc/00000000", log_addr[base], log_addr[base+1]); end
        end
    endtask

    task automatic test_err_clr();
        bit ok;
        issue_cmd(1'b0, 32'h0000_0400, 8'd1, 32'h5555_AAAB, 1'b0);
        wait_done(20, ok);
        checks++; if (err_cnt !== 16'd2 || first_err_addr !== 32'h400) begin errors++; $display("FAIL clr_pre: got cnt=%0d first=%h expected 2/00000400", err_cnt, first_err_addr); end
        ack_en = 1'b0;
        issue_cmd(1'b0, 32'h0000_0200, 8'd0, 32'h0, 1'b0);
        wait_done(60, ok);
        ack_en = 1'b1;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL clr_pre_terr: got %b expected 1", timeout_err); end
        @(negedge sys_clk); err_clr = 1'b1;
        @(negedge sys_clk); err_clr = 1'b0; #1;
        checks++; if (err_cnt !== 16'd0 || first_err_addr !== 32'h0 || timeout_err !== 1'b0) begin errors++; $display("FAIL clr_all: got cnt=%0d first=%h terr=%b expected 0/0/0", err_cnt, first_err_addr, timeout_err); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        repeat (3) @(negedge sys_clk);
        test_reset();
        @(negedge sys_clk);
        RESETN = 1'b1;
        test_write_burst();
        test_read_back();
        test_mismatch();
        test_single();
        test_timeout();
        test_reset_mid_burst();
        test_after_reset();
        test_wrap();
        test_err_clr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
